sram_arbiter: RTL

- Shares one synchronous single-port SRAM between the instruction-fetch requester (port `i_*`) and the data-memory requester (port `d_*`).
- Grants at most one request per cycle.
- Tracks in-flight accesses through a tag pipeline matched to the SRAM read latency.
- Routes each read/write completion back to its owner.
- Sits between the pipeline's fetch/memory stages and the SRAM macro at the CPU top level.

---
 rtl/sram_arbiter.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/sram_arbiter.sv
// -----------------------------------------------------------------------------
// sram_arbiter
//
// Shares one synchronous single-port SRAM between the instruction-fetch
// requester (i_*) and the data-memory requester (d_*). At most one request is
// granted per cycle; the granted port's command is muxed onto the SRAM pins.
// A {valid, owner} tag pipeline RD_LAT stages deep follows every enabled SRAM
// cycle, so the completion (data_ok + rdata) is routed back to the port that
// issued it exactly RD_LAT cycles after its addr_ok. Completions therefore
// come back in grant order, at most one per cycle.
//
// Parameters
//   RD_LAT      SRAM read latency in cycles, legal range 1..4.
//
// Configuration macro
//   SRAM_ARB_RR_EN  defined   : round-robin on conflict (port not granted last
//                               wins; a lone requester is always granted).
//                   undefined : fixed priority, data port always wins.
//
// Ports
//   clk          in   1   clock, rising edge
//   resetn       in   1   asynchronous active-low reset
//   i_req        in   1   fetch request valid
//   i_we         in   4   fetch byte write enables
//   i_addr       in  32   fetch address
//   i_wdata      in  32   fetch write data
//   i_addr_ok    out  1   fetch request accepted this cycle
//   i_data_ok    out  1   fetch completion (read data or write done)
//   i_rdata      out 32   fetch read data, valid with i_data_ok
//   d_*                   same set of ports for the data requester
//   sram_en      out  1   SRAM enable
//   sram_we      out  4   SRAM byte write enables
//   sram_addr    out 32   SRAM address
//   sram_wdata   out 32   SRAM write data
//   sram_rdata   in  32   SRAM read data, RD_LAT cycles after the enabled cycle
// -----------------------------------------------------------------------------
module sram_arbiter #(
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        i_req,
    input  logic [3:0]  i_we,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        i_addr_ok,
    output logic        i_data_ok,
    output logic [31:0] i_rdata,

    input  logic        d_req,
    input  logic [3:0]  d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_addr_ok,
    output logic        d_data_ok,
    output logic [31:0] d_rdata,

    output logic        sram_en,
    output logic [3:0]  sram_we,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata
);

    // -------------------------------------------------------------------------
    // Arbitration
    // -------------------------------------------------------------------------
    logic gnt_i;
    logic gnt_d;

    // 1 = most recent grant went to the data port.
    logic last_d_reg;
    logic last_d_next;

    always_comb begin
        gnt_i = 1'b0;
        gnt_d = 1'b0;
        // Grants are gated by reset combinationally so that nothing reaches
        // the SRAM or the requesters while resetn is held low.
        if (resetn) begin
`ifdef SRAM_ARB_RR_EN
            if (i_req && d_req) begin
                // Conflict: the port that did not win last time wins now.
                if (last_d_reg) begin
                    gnt_i = 1'b1;
                end else begin
                    gnt_d = 1'b1;
                end
            end else begin
                gnt_i = i_req;
                gnt_d = d_req;
            end
`else
            gnt_d = d_req;
            gnt_i = i_req & ~d_req;
`endif
        end
    end

    // The priority bit follows every grant in both configurations; under
    // fixed priority it simply has no effect on the decision.
    always_comb begin
        last_d_next = last_d_reg;
        if (gnt_i || gnt_d) begin
            last_d_next = gnt_d;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_d_reg <= 1'b0;
        end else begin
            last_d_reg <= last_d_next;
        end
    end

    assign i_addr_ok = gnt_i;
    assign d_addr_ok = gnt_d;

    // -------------------------------------------------------------------------
    // SRAM command mux
    // -------------------------------------------------------------------------
    always_comb begin
        sram_en    = gnt_i | gnt_d;
        sram_we    = 4'h0;
        sram_addr  = 32'h0;
        sram_wdata = 32'h0;
        if (gnt_d) begin
            sram_we    = d_we;
            sram_addr  = d_addr;
            sram_wdata = d_wdata;
        end else if (gnt_i) begin
            sram_we    = i_we;
            sram_addr  = i_addr;
            sram_wdata = i_wdata;
        end
    end

    // -------------------------------------------------------------------------
    // Tag pipeline: one {valid, owner} entry per SRAM latency cycle.
    // Owner bit 1 = data port. Stage RD_LAT-1 lines up with sram_rdata.
    // -------------------------------------------------------------------------
    logic [RD_LAT-1:0] tag_valid_reg;
    logic [RD_LAT-1:0] tag_owner_reg;
    logic [RD_LAT-1:0] tag_valid_next;
    logic [RD_LAT-1:0] tag_owner_next;

    genvar gi;
    generate
        for (gi = 0; gi < RD_LAT; gi++) begin : g_tag
            if (gi == 0) begin : g_head
                assign tag_valid_next[gi] = sram_en;
                assign tag_owner_next[gi] = gnt_d;
            end else begin : g_shift
                assign tag_valid_next[gi] = tag_valid_reg[gi-1];
                assign tag_owner_next[gi] = tag_owner_reg[gi-1];
            end
        end
    endgenerate

    // Clearing the pipeline on reset is what drops in-flight accesses: no
    // completion can surface for a grant issued before reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tag_valid_reg <= '0;
            tag_owner_reg <= '0;
        end else begin
            tag_valid_reg <= tag_valid_next;
            tag_owner_reg <= tag_owner_next;
        end
    end

    // -------------------------------------------------------------------------
    // Completion routing
    // -------------------------------------------------------------------------
    logic done_valid;
    logic done_d;

    assign done_valid = tag_valid_reg[RD_LAT-1];
    assign done_d     = tag_owner_reg[RD_LAT-1];

    assign i_data_ok = done_valid & ~done_d;
    assign d_data_ok = done_valid &  done_d;

    // Only the owner of the completing access sees the SRAM data; the other
    // port (and both ports when nothing completes) reads zero.
    assign i_rdata = i_data_ok ? sram_rdata : 32'h0;
    assign d_rdata = d_data_ok ? sram_rdata : 32'h0;

endmodule
